e1_rx_liu_ctrl: RTL
===================

E1_RX_LIU_CTRL -- requirements
Module: e1_rx_liu_ctrl

Interface
REQ-001 SHALL have parameter CLK_TO, default 63: number of consecutive clk cycles without a bit strobe that counts as loss of clock.
REQ-002 SHALL have parameter LOCK_CNT, default 16: number of consecutive in-time strobes required to lock.
REQ-003 SHALL have parameter ZERO_LOS, default 255: number of consecutive zero bits that counts as loss of signal.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, 1 bit: received bit from the LIU front end.
REQ-007 SHALL have port in_valid, input, 1 bit: one-cycle bit strobe that qualifies in_data.
REQ-008 SHALL have port ctrl_enable, input, 1 bit: run/stop control for the block.
REQ-009 SHALL have port out_data, output, 1 bit: gated bit.
REQ-010 SHALL have port out_valid, output, 1 bit: gated strobe.
REQ-011 SHALL have port stat_state, output, 2 bits: current state, encoded 0=DISABLED, 1=ACQUIRE, 2=LOCKED, 3=LOST.
REQ-012 SHALL have port stat_los_clk, output, 1 bit: loss of clock.
REQ-013 SHALL have port stat_los_zero, output, 1 bit: zero-run loss of signal.
REQ-014 SHALL have port stat_ais, output, 1 bit: AIS detected.
REQ-015 SHALL have port evt_lock, output, 1 bit: one-cycle pulse on entry to LOCKED.

Function
REQ-016 SHALL keep a gap counter gap_cnt (width clog2(CLK_TO+1)).
- Cleared to 0 on in_valid.
- Otherwise incremented, saturating at CLK_TO.
- timeout is defined as gap_cnt==CLK_TO.
REQ-017 SHALL keep a lock counter that counts in-time strobes in ACQUIRE.
REQ-018 SHALL apply these state transitions, registered, taking effect on the next edge:
- Any state with ctrl_enable=0 -> DISABLED.
- DISABLED with ctrl_enable=1 -> ACQUIRE, with gap_cnt, lock counter and zero-run counter cleared.
- ACQUIRE, on the strobe that brings the lock counter to LOCK_CNT -> LOCKED.
- ACQUIRE on timeout without a strobe -> lock counter cleared, stay in ACQUIRE.
- LOCKED on timeout without a strobe -> LOST.
- LOST on in_valid -> ACQUIRE, with the lock counter set to 1.
REQ-019 SHALL give in_valid priority when it coincides with timeout.
- In LOCKED: stay LOCKED.
- In ACQUIRE: the strobe is counted and the lock counter restarts at 1.
REQ-020 SHALL register out_data<=in_data and out_valid<=in_valid && stat_state==LOCKED, giving 1-cycle latency.
- No out_valid is produced on the strobe that causes entry to LOCKED.
REQ-021 SHALL drive stat_los_clk as follows:
- Set on the LOCKED->LOST transition.
- Cleared on entry to LOCKED or DISABLED.
REQ-022 SHALL count the zero run only while LOCKED, once per strobe.
- The counter is 8 bits and saturates at ZERO_LOS.
- Reset by a strobe carrying in_data=1.
- stat_los_zero=1 while the count equals ZERO_LOS, and clears on the cycle after a 1 bit is received.
- stat_los_zero does not change state.
REQ-023 SHALL run AIS detection over a fixed 512-bit window while LOCKED.
- Counters: 9-bit strobe counter and 2-bit saturating zero counter.
- At the end of each window, stat_ais<=(zeros<3); the counters then restart.
- Leaving LOCKED restarts the window and leaves stat_ais unchanged.
- Entry to DISABLED clears stat_ais.
REQ-024 SHALL pulse evt_lock high for exactly one cycle, aligned with stat_state first reading 2.
REQ-025 SHALL update statuses in DISABLED only through reset or REQ-021 and REQ-023; in DISABLED out_valid=0.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set the following, overriding ctrl_enable:
- stat_state=DISABLED.
- out_data=0, out_valid=0, evt_lock=0.
- All stat_* outputs 0.
- All counters 0.
REQ-027 SHALL allow reset to abort any state mid-operation, with no residual strobe on out_valid the following cycle.

Verification
REQ-028 SHALL cover lock acquisition: ctrl_enable=1, strobes every 15 cycles.
- After the 16th strobe: stat_state=2 and evt_lock=1 for 1 cycle.
- The 17th strobe gives out_valid=1 one cycle later, with out_data equal to that strobe's in_data.
REQ-029 SHALL cover loss of clock: in LOCKED, stop strobes.
- stat_state=3 and stat_los_clk=1 the cycle after gap_cnt reaches 63.
- The next strobe gives state 1, and 15 more strobes relock with stat_los_clk=0.
REQ-030 SHALL cover the zero run: in LOCKED, 255 zero bits give stat_los_zero=1, with state still 2.
- 254 zeros then a 1 give stat_los_zero=0 throughout.
- A 1 after LOS gives stat_los_zero=0 the next cycle.
REQ-031 SHALL cover AIS: in LOCKED, a 512-bit window of all ones gives stat_ais=1.
- The next window with exactly 3 zeros gives stat_ais=0.
- A window with 2 zeros gives stat_ais=1.
REQ-032 SHALL cover coincident strobe and timeout: in LOCKED, a strobe arriving exactly at gap_cnt=63 keeps state 2 and gives out_valid=1.
REQ-033 SHALL cover control and reset:
- rst pulsed while LOCKED with strobes running: all outputs 0 and state 0 the next cycle.
- ctrl_enable=0 in LOCKED: state 0 the next cycle, with out_valid=0 afterwards.

Source files
------------

// File: rtl/e1_rx_liu_ctrl.sv
// E1 receive line-interface control: clock-presence lock FSM, strobe gating,
// loss-of-clock, zero-run loss-of-signal and AIS detection.
module e1_rx_liu_ctrl #(
    parameter int unsigned CLK_TO   = 63,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned ZERO_LOS = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_data,
    input  logic       in_valid,
    input  logic       ctrl_enable,
    output logic       out_data,
    output logic       out_valid,
    output logic [1:0] stat_state,
    output logic       stat_los_clk,
    output logic       stat_los_zero,
    output logic       stat_ais,
    output logic       evt_lock
);
    localparam int unsigned GapW  = $clog2(CLK_TO + 1);
    localparam int unsigned LockW = $clog2(LOCK_CNT + 1);
    localparam logic [GapW-1:0]  GapMax  = GapW'(CLK_TO);
    localparam logic [LockW-1:0] LockMax = LockW'(LOCK_CNT);
    localparam logic [LockW-1:0] LockOne = LockW'(1);
    localparam logic [7:0]       ZeroMax = 8'(ZERO_LOS);

    typedef enum logic [1:0] {
        StDisabled = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2,
        StLost     = 2'd3
    } state_e;

    state_e           state_q;
    logic [GapW-1:0]  gap_q;
    logic [LockW-1:0] lock_q;
    logic [7:0]       zero_q;
    logic [8:0]       win_q;
    logic [1:0]       ais_zero_q;

    logic             timeout;
    logic [GapW-1:0]  gap_d;
    logic [LockW-1:0] lock_d;
    logic [7:0]       zero_d;
    logic [1:0]       ais_zero_d;

    assign timeout    = (gap_q == GapMax);
    assign gap_d      = in_valid ? '0 : (timeout ? GapMax : gap_q + 1'b1);
    // A strobe coinciding with timeout is counted but restarts the run.
    assign lock_d     = timeout ? LockOne : lock_q + 1'b1;
    assign zero_d     = in_data ? 8'd0 : ((zero_q == ZeroMax) ? ZeroMax : zero_q + 8'd1);
    assign ais_zero_d = (in_data || ais_zero_q == 2'd3) ? ais_zero_q : ais_zero_q + 2'd1;

    assign stat_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StDisabled;
            gap_q         <= '0;
            lock_q        <= '0;
            zero_q        <= '0;
            win_q         <= '0;
            ais_zero_q    <= '0;
            out_data      <= 1'b0;
            out_valid     <= 1'b0;
            stat_los_clk  <= 1'b0;
            stat_los_zero <= 1'b0;
            stat_ais      <= 1'b0;
            evt_lock      <= 1'b0;
        end else begin
            out_data  <= in_data;
            out_valid <= in_valid && (state_q == StLocked);
            evt_lock  <= 1'b0;
            gap_q     <= gap_d;

            // Zero-run and AIS window only advance on strobes seen while locked.
            if (state_q == StLocked) begin
                if (in_valid) begin
                    zero_q        <= zero_d;
                    stat_los_zero <= (zero_d == ZeroMax);
                    if (win_q == 9'h1ff) begin
                        stat_ais   <= (ais_zero_d != 2'd3);
                        win_q      <= '0;
                        ais_zero_q <= '0;
                    end else begin
                        win_q      <= win_q + 9'd1;
                        ais_zero_q <= ais_zero_d;
                    end
                end
            end else begin
                win_q      <= '0;
                ais_zero_q <= '0;
            end

            if (!ctrl_enable) begin
                state_q      <= StDisabled;
                stat_los_clk <= 1'b0;
                stat_ais     <= 1'b0;
            end else begin
                unique case (state_q)
                    StDisabled: begin
                        state_q       <= StAcquire;
                        gap_q         <= '0;
                        lock_q        <= '0;
                        zero_q        <= '0;
                        stat_los_zero <= 1'b0;
                    end
                    StAcquire: begin
                        if (in_valid) begin
                            lock_q <= lock_d;
                            if (lock_d == LockMax) begin
                                state_q      <= StLocked;
                                evt_lock     <= 1'b1;
                                stat_los_clk <= 1'b0;
                            end
                        end else if (timeout) begin
                            lock_q <= '0;
                        end
                    end
                    StLocked: begin
                        if (timeout && !in_valid) begin
                            state_q      <= StLost;
                            stat_los_clk <= 1'b1;
                        end
                    end
                    StLost: begin
                        if (in_valid) begin
                            state_q <= StAcquire;
                            lock_q  <= LockOne;
                        end
                    end
                    default: state_q <= StDisabled;
                endcase
            end
        end
    end

endmodule
